// File: rtl/hidden_layer_collector_if.sv
// Neuron-capture inputs plus the outgoing valid/ready/last value stream of the hidden-layer collector.
interface hidden_layer_collector_if #(
    parameter int NUM_NEURONS = 30,
    parameter int DATA_WIDTH  = 16
);
    logic [NUM_NEURONS*DATA_WIDTH-1:0] in_data;
    logic [NUM_NEURONS-1:0]            in_valid;
    logic [DATA_WIDTH-1:0]             out_data;
    logic                              out_valid;
    logic                              out_ready;
    logic                              out_last;

    modport master (
        output in_data, in_valid, out_ready,
        input  out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output out_data, out_valid, out_last
    );
endinterface

// File: rtl/hidden_layer_collector.sv
// Collects one activation per neuron (any order), then streams the full vector neuron 0..N-1
// on a valid/ready handshake with last on the final value.
module hidden_layer_collector #(
    parameter int NUM_NEURONS = 30,
    parameter int DATA_WIDTH  = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hidden_layer_collector_if.slave bus,
    input  logic                  i_clr_overrun,
    output logic                  o_busy,
    output logic                  o_overrun,
    output logic [CNT_WIDTH-1:0]  o_frame_cnt
);
    localparam int IDX_W = $clog2(NUM_NEURONS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    typedef enum logic {COLLECT, SEND} state_t;

    state_t                                  r_state, w_state_nxt;
    logic [NUM_NEURONS-1:0]                  r_got, w_got_nxt;
    logic [IDX_W-1:0]                        r_idx, w_idx_nxt;
    logic [CNT_WIDTH-1:0]                    r_frame_cnt, w_frame_cnt_nxt;
    logic                                    r_overrun, w_overrun_nxt;
    logic [NUM_NEURONS-1:0]                  w_cap;
    logic                                    w_drop;
    logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0]  r_buf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= COLLECT;
            r_got       <= '0;
            r_idx       <= '0;
            r_frame_cnt <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_got       <= w_got_nxt;
            r_idx       <= w_idx_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_overrun   <= w_overrun_nxt;
        end
    end

    // Capture storage needs no reset: got flags gate every read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (w_cap[i]) r_buf[i] <= bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_got_nxt       = r_got;
        w_idx_nxt       = r_idx;
        w_frame_cnt_nxt = r_frame_cnt;
        w_cap           = '0;
        w_drop          = 1'b0;
        case (r_state)
            COLLECT: begin
                w_cap     = bus.in_valid & ~r_got;
                w_drop    = |(bus.in_valid & r_got);
                w_got_nxt = r_got | bus.in_valid;
                if (&w_got_nxt) begin
                    w_state_nxt = SEND;
                    w_idx_nxt   = '0;
                end
            end
            SEND: begin
                // Nothing is captured while streaming; the next frame starts clean.
                w_drop = |bus.in_valid;
                if (bus.out_ready) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt     = COLLECT;
                        w_got_nxt       = '0;
                        w_idx_nxt       = '0;
                        w_frame_cnt_nxt = r_frame_cnt + 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            default: ;
        endcase
        w_overrun_nxt = w_drop | (r_overrun & ~i_clr_overrun);
    end

    assign bus.out_valid = (r_state == SEND);
    assign bus.out_data  = r_buf[r_idx];
    assign bus.out_last  = (r_state == SEND) && (r_idx == LAST_IDX);
    assign o_busy        = (r_state == SEND);
    assign o_overrun     = r_overrun;
    assign o_frame_cnt   = r_frame_cnt;
endmodule
